// File: rtl/snoopy_pkg.sv
// ============================================================================
//  snoopy_pkg
//  Shared screen, colour and drawer-state definitions for the Snoopy sprite path.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package snoopy_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BG_COLOUR  = 3'b000;
    localparam logic [COLOUR_W-1:0] KEY_COLOUR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/snoopy_sprite_rom.sv
// ============================================================================
//  snoopy_sprite_rom
//  Synchronous-read sprite image ROM, one-cycle latency, address-pattern image.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module snoopy_sprite_rom
    import snoopy_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clock,
    input  logic [AW-1:0]       addr,
    output logic [COLOUR_W-1:0] data
);

    logic [COLOUR_W-1:0] mem [DEPTH];

    // Built-in image: each texel carries the low bits of its own address.
    for (genvar i = 0; i < DEPTH; i++) begin : g_image
        assign mem[i] = COLOUR_W'(i);
    end

    always_ff @(posedge clock) begin
        data <= mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/snoopy_sprite_drawer.sv
// ============================================================================
//  snoopy_sprite_drawer
//  Per-frame erase of the old sprite box and redraw at the new position.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module snoopy_sprite_drawer
    import snoopy_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int SCREEN_W = snoopy_pkg::SCREEN_W,
    parameter int SCREEN_H = snoopy_pkg::SCREEN_H,
    parameter logic [2:0] BG_COLOUR  = snoopy_pkg::BG_COLOUR,
    parameter logic [2:0] KEY_COLOUR = snoopy_pkg::KEY_COLOUR
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                frame_tick,
    input  logic [7:0]          snoopy_x,
    input  logic [6:0]          snoopy_y,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                draw_done
);

    localparam int CW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RW    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int DEPTH = SPRITE_W * SPRITE_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      new_x, old_x, base_x;
    logic [6:0]      new_y, old_y, base_y;
    logic            old_valid;
    logic            accept, issue, issue_draw, finish;
    logic            last_col, last_row;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;
    logic [AW-1:0]   rom_addr;
    logic [COLOUR_W-1:0] rom_data;
    logic            draw_slot;

    assign last_col = (col_q == CW'(SPRITE_W - 1));
    assign last_row = (row_q == RW'(SPRITE_H - 1));

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_draw = 1'b0;
        finish     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    accept = 1'b1;
                    col_d  = '0;
                    row_d  = '0;
                    if (!old_valid) begin
                        state_d = S_DRAW;
                    end else if (snoopy_x != old_x || snoopy_y != old_y) begin
                        state_d = S_ERASE;
                    end
                end
            end
            S_ERASE, S_DRAW: begin
                issue      = 1'b1;
                issue_draw = (state_q == S_DRAW);
                if (last_col) begin
                    col_d = '0;
                    row_d = last_row ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (last_col && last_row) begin
                    state_d = (state_q == S_ERASE) ? S_DRAW : S_FLUSH;
                end
            end
            S_FLUSH: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign base_x   = issue_draw ? new_x : old_x;
    assign base_y   = issue_draw ? new_y : old_y;
    assign sum_x    = {1'b0, base_x} + 9'(col_q);
    assign sum_y    = {1'b0, base_y} + 8'(row_q);
    assign rom_addr = AW'(row_q) * AW'(SPRITE_W) + AW'(col_q);

    snoopy_sprite_rom #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rom (
        .clock (clock),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    // Coordinates and strobe are registered alongside the ROM read so that
    // every slot reaches the adapter exactly one cycle after issue.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            new_x     <= '0;
            new_y     <= '0;
            old_x     <= '0;
            old_y     <= '0;
            old_valid <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_plot  <= 1'b0;
            draw_slot <= 1'b0;
            draw_done <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (accept) begin
                new_x <= snoopy_x;
                new_y <= snoopy_y;
            end
            if (finish) begin
                old_x     <= new_x;
                old_y     <= new_y;
                old_valid <= 1'b1;
            end
            draw_done <= finish;
            vga_x     <= sum_x[7:0];
            vga_y     <= sum_y[6:0];
            vga_plot  <= issue && (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
            draw_slot <= issue_draw;
        end
    end

    assign vga_colour = (!draw_slot || rom_data == KEY_COLOUR) ? BG_COLOUR : rom_data;
    assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire
